// File: rtl/alu_pkg.sv
// Shared types for the ALU request issuer: opcode, error code and FSM state encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND    = 4'd0,
    OP_OR     = 4'd1,
    OP_NOT    = 4'd2,
    OP_ADD    = 4'd3,
    OP_SUB    = 4'd4,
    OP_INC    = 4'd5,
    OP_SHL    = 4'd6,
    OP_SHR    = 4'd7,
    OP_POPCNT = 4'd8
  } alu_op_t;

  // Highest opcode the ALU implements; anything above is answered locally as illegal.
  localparam logic [3:0] OP_LAST = 4'd8;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_ILLEGAL = 2'b01,
    ERR_TIMEOUT = 2'b10
  } rsp_err_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } issuer_state_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_LAST);
  endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Request FIFO: DEPTH entries of W bits, head entry visible combinationally.
// Latency: an entry pushed at cycle N is visible at the head (empty=0) at N+1.
// Backpressure: full refuses pushes; no same-cycle bypass, a pop does not free space for a push in that cycle.
//
// Ports: clk, rst (sync, active-high); push/push_dat/full on the write side;
//        pop/head_dat/empty on the read side.
module alu_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  output logic         full,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_req_issuer.sv
// ALU initiator: queues client requests, issues them one at a time to the ALU, returns result/tag/error.
// Latency: push at N, pop at N+1, alu_valid_i at N+2, rsp_valid at N+3 with a combinational ALU.
// Backpressure: req_ready=!full; the FSM holds the response in RESP until rsp_ready, stalling further issues.
//
// Ports: clk, rst (sync, active-high);
//        req_valid/req_ready/req_a/req_b/req_op/req_tag  upstream request channel;
//        alu_a/alu_b/alu_op/alu_valid_i, alu_z/alu_valid_o  ALU handshake;
//        rsp_valid/rsp_ready/rsp_z/rsp_tag/rsp_err  downstream response channel; busy.
module alu_req_issuer
  import alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [63:0]      req_a,
  input  logic [63:0]      req_b,
  input  logic [3:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic [63:0]      alu_a,
  output logic [63:0]      alu_b,
  output logic [3:0]       alu_op,
  output logic             alu_valid_i,
  input  logic [63:0]      alu_z,
  input  logic             alu_valid_o,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_z,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [1:0]       rsp_err,
  output logic             busy
);

  localparam int ENT_W = TAG_W + 4 + 64 + 64;
  localparam int TW    = $clog2(TIMEOUT);

  issuer_state_t    state;
  logic [TW-1:0]    timer;

  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [ENT_W-1:0] head_dat;
  logic [TAG_W-1:0] h_tag;
  logic [3:0]       h_op;
  logic [63:0]      h_a;
  logic [63:0]      h_b;

  assign {h_tag, h_op, h_b, h_a} = head_dat;

  // Pop only from IDLE, so a request is dequeued once per FSM round trip.
  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
  assign req_ready = !fifo_full;
  assign busy      = (state != ST_IDLE) || !fifo_empty;

  alu_req_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (req_valid),
    .push_dat ({req_tag, req_op, req_b, req_a}),
    .full     (fifo_full),
    .pop      (fifo_pop),
    .head_dat (head_dat),
    .empty    (fifo_empty)
  );

  // alu_a/b/op double as the operand hold registers; rsp_tag holds the tag.
  // alu_valid_i is set on entry to ISSUE and cleared on leaving it, so it is a single-cycle strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      timer       <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      alu_valid_i <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_z       <= '0;
      rsp_tag     <= '0;
      rsp_err     <= ERR_OK;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            alu_a   <= h_a;
            alu_b   <= h_b;
            alu_op  <= h_op;
            rsp_tag <= h_tag;
            if (!op_is_legal(h_op)) begin
              // Answered locally; the ALU never sees this request.
              rsp_z     <= '0;
              rsp_err   <= ERR_ILLEGAL;
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end else begin
              alu_valid_i <= 1'b1;
              state       <= ST_ISSUE;
            end
          end
        end

        ST_ISSUE: begin
          alu_valid_i <= 1'b0;
          if (alu_valid_o) begin
            // Combinational ALU answers in the issue cycle itself.
            rsp_z     <= alu_z;
            rsp_err   <= ERR_OK;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            timer <= '0;
            state <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (alu_valid_o) begin
            rsp_z     <= alu_z;
            rsp_err   <= ERR_OK;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            rsp_z     <= '0;
            rsp_err   <= ERR_TIMEOUT;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_issuer.sv
// Self-checking bench for alu_req_issuer with a bench-side ALU responder (combinational, slow, silent).
// Latency: n/a.
// Backpressure: rsp_ready is driven per scenario.
module tb_alu_req_issuer;
  import alu_pkg::*;

  localparam int TAG_W = 4;

  typedef struct {
    logic [63:0]      z;
    logic [TAG_W-1:0] tag;
    logic [1:0]       err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [63:0]      req_a;
  logic [63:0]      req_b;
  logic [3:0]       req_op;
  logic [TAG_W-1:0] req_tag;
  logic [63:0]      alu_a;
  logic [63:0]      alu_b;
  logic [3:0]       alu_op;
  logic             alu_valid_i;
  logic [63:0]      alu_z;
  logic             alu_valid_o;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [63:0]      rsp_z;
  logic [TAG_W-1:0] rsp_tag;
  logic [1:0]       rsp_err;
  logic             busy;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  exp_t e;

  logic [1:0] mode  = 2'd0;   // 0 combinational, 1 answers 5 cycles late, 2 never answers
  logic       stray = 1'b0;
  logic [2:0] slow_cnt = 3'd0;

  alu_req_issuer #(.DEPTH(4), .TAG_W(TAG_W), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .req_op(req_op), .req_tag(req_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_valid_i(alu_valid_i),
    .alu_z(alu_z), .alu_valid_o(alu_valid_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_z(rsp_z), .rsp_tag(rsp_tag),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] alu_model(input logic [63:0] a, input logic [63:0] b,
                                            input logic [3:0] op);
    case (op)
      OP_AND:    return a & b;
      OP_OR:     return a | b;
      OP_NOT:    return ~a;
      OP_ADD:    return a + b;
      OP_SUB:    return a - b;
      OP_INC:    return a + 64'd1;
      OP_SHL:    return a << b[5:0];
      OP_SHR:    return a >> b[5:0];
      OP_POPCNT: return 64'($countones(a));
      default:   return 64'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (alu_valid_i)                         slow_cnt <= 3'd1;
    else if (slow_cnt != 0 && slow_cnt < 5)  slow_cnt <= slow_cnt + 3'd1;
    else                                     slow_cnt <= 3'd0;
  end

  always_comb begin
    alu_valid_o = stray;
    alu_z       = 64'hBAD;
    case (mode)
      2'd0: begin
        if (alu_valid_i) alu_valid_o = 1'b1;
        alu_z = alu_model(alu_a, alu_b, alu_op);
      end
      2'd1: begin
        if (slow_cnt == 3'd5) alu_valid_o = 1'b1;
        alu_z = 64'hDEAD;
      end
      default: ;
    endcase
  end

  // Present one request for a single cycle (caller ensures req_ready) and queue its expectation.
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op,
                      input logic [TAG_W-1:0] tag, input logic [63:0] z_exp, input logic [1:0] err_exp);
    req_valid = 1'b1; req_a = a; req_b = b; req_op = op; req_tag = tag;
    sb.push_back('{z: z_exp, tag: tag, err: err_exp});
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; req_tag = '0; rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if ({alu_valid_i, rsp_valid, busy} !== 3'b000 || alu_a !== 64'd0 || alu_op !== 4'd0 ||
        rsp_z !== 64'd0 || rsp_tag !== '0 || rsp_err !== 2'b00) begin
      fails++;
      $display("FAIL reset_outputs: vi=%b rv=%b busy=%b a=%h op=%h z=%h tag=%h err=%b, all required 0",
               alu_valid_i, rsp_valid, busy, alu_a, alu_op, rsp_z, rsp_tag, rsp_err);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1) begin
      fails++; $display("FAIL reset_req_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_single_add();
    mode = 2'd0; rsp_ready = 1'b1;
    send(64'd5, 64'd7, OP_ADD, 4'd3, 64'd12, ERR_OK);
    for (int cyc = 1; cyc <= 7; cyc++) begin
      tests++;
      if (alu_valid_i !== (cyc == 2)) begin
        fails++; $display("FAIL add_issue_cyc%0d: alu_valid_i=%b want %b", cyc, alu_valid_i, cyc == 2);
      end
      tests++;
      if (rsp_valid !== (cyc == 3)) begin
        fails++; $display("FAIL add_rsp_cyc%0d: rsp_valid=%b want %b", cyc, rsp_valid, cyc == 3);
      end
      if (rsp_valid && rsp_ready) begin
        tests++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL add_rsp: unexpected response tag=%0d", rsp_tag);
        end else begin
          e = sb.pop_front();
          if (rsp_z !== e.z || rsp_tag !== e.tag || rsp_err !== e.err) begin
            fails++;
            $display("FAIL add_rsp: got z=%h tag=%0d err=%b want z=%h tag=%0d err=%b",
                     rsp_z, rsp_tag, rsp_err, e.z, e.tag, e.err);
          end
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_fill();
    logic [3:0] ops [5];
    int accepted = 0;
    int cycles   = 0;
    int got      = 0;
    ops = '{OP_AND, OP_SUB, OP_SHL, OP_POPCNT, OP_NOT};
    mode = 2'd0; rsp_ready = 1'b0;
    while (accepted < 5 && cycles < 20) begin
      if (req_ready) begin
        logic [63:0] a;
        logic [63:0] b;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        req_valid = 1'b1; req_a = a; req_b = b; req_op = ops[accepted]; req_tag = 4'(accepted + 10);
        sb.push_back('{z: alu_model(a, b, ops[accepted]), tag: 4'(accepted + 10), err: ERR_OK});
        accepted++;
      end else begin
        req_valid = 1'b0;
      end
      cycles++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    tests++;
    if (cycles !== 5) begin
      fails++; $display("FAIL fill_accept: 5 requests took %0d cycles, want 5", cycles);
    end
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b0 || busy !== 1'b1 || rsp_valid !== 1'b1) begin
      fails++;
      $display("FAIL fill_full: req_ready=%b busy=%b rsp_valid=%b want 0 1 1", req_ready, busy, rsp_valid);
    end
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      if (rsp_valid && rsp_ready) begin
        tests++;
        got++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL fill_rsp: unexpected response tag=%0d", rsp_tag);
        end else begin
          e = sb.pop_front();
          if (rsp_z !== e.z || rsp_tag !== e.tag || rsp_err !== e.err) begin
            fails++;
            $display("FAIL fill_rsp: got z=%h tag=%0d err=%b want z=%h tag=%0d err=%b",
                     rsp_z, rsp_tag, rsp_err, e.z, e.tag, e.err);
          end
        end
      end
      @(negedge clk);
    end
    tests++;
    if (got !== 5 || sb.size() !== 0) begin
      fails++; $display("FAIL fill_drain: got %0d responses, %0d still expected; want 5 and 0", got, sb.size());
    end
  endtask

  task automatic test_illegal();
    int got = 0;
    mode = 2'd0; rsp_ready = 1'b1;
    send(64'd1, 64'd2, 4'd12, 4'd9, 64'd0, ERR_ILLEGAL);
    for (int cyc = 1; cyc <= 6; cyc++) begin
      tests++;
      if (alu_valid_i !== 1'b0) begin
        fails++; $display("FAIL illegal_no_issue_cyc%0d: alu_valid_i=%b want 0", cyc, alu_valid_i);
      end
      if (rsp_valid && rsp_ready) begin
        tests++;
        got++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL illegal_rsp: unexpected response tag=%0d", rsp_tag);
        end else begin
          e = sb.pop_front();
          if (rsp_z !== e.z || rsp_tag !== e.tag || rsp_err !== e.err) begin
            fails++;
            $display("FAIL illegal_rsp: got z=%h tag=%0d err=%b want z=%h tag=%0d err=%b",
                     rsp_z, rsp_tag, rsp_err, e.z, e.tag, e.err);
          end
        end
      end
      @(negedge clk);
    end
    tests++;
    if (got !== 1) begin
      fails++; $display("FAIL illegal_count: got %0d responses want 1", got);
    end
  endtask

  task automatic test_slow();
    int got    = 0;
    int pulses = 0;
    mode = 2'd1; rsp_ready = 1'b1;
    send(64'd1, 64'd2, OP_ADD, 4'd4, 64'hDEAD, ERR_OK);
    for (int cyc = 1; cyc <= 15; cyc++) begin
      if (alu_valid_i) pulses++;
      if (rsp_valid && rsp_ready) begin
        tests++;
        got++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL slow_rsp: unexpected response tag=%0d", rsp_tag);
        end else begin
          e = sb.pop_front();
          if (rsp_z !== e.z || rsp_tag !== e.tag || rsp_err !== e.err) begin
            fails++;
            $display("FAIL slow_rsp: got z=%h tag=%0d err=%b want z=%h tag=%0d err=%b",
                     rsp_z, rsp_tag, rsp_err, e.z, e.tag, e.err);
          end
        end
      end
      @(negedge clk);
    end
    tests++;
    if (pulses !== 1 || got !== 1) begin
      fails++; $display("FAIL slow_pulse: alu_valid_i cycles=%0d responses=%0d want 1 and 1", pulses, got);
    end
  endtask

  task automatic test_timeout();
    int issue_cyc = -1;
    int rsp_cyc   = -1;
    int got       = 0;
    mode = 2'd2; rsp_ready = 1'b0;
    send(64'd3, 64'd4, OP_ADD, 4'd5, 64'd0, ERR_TIMEOUT);
    for (int cyc = 1; cyc <= 40 && rsp_cyc < 0; cyc++) begin
      if (alu_valid_i && issue_cyc < 0) issue_cyc = cyc;
      if (rsp_valid) rsp_cyc = cyc;
      else @(negedge clk);
    end
    tests++;
    if (issue_cyc < 0 || rsp_cyc < 0 || rsp_cyc - issue_cyc !== 17) begin
      fails++; $display("FAIL timeout_latency: issue=%0d rsp=%0d want rsp 17 after issue", issue_cyc, rsp_cyc);
    end
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_err !== 2'b10 || rsp_z !== 64'd0) begin
      fails++;
      $display("FAIL timeout_stray: rsp_valid=%b err=%b z=%h want 1 10 0", rsp_valid, rsp_err, rsp_z);
    end
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (rsp_valid && rsp_ready) begin
        tests++;
        got++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL timeout_rsp: unexpected response tag=%0d", rsp_tag);
        end else begin
          e = sb.pop_front();
          if (rsp_z !== e.z || rsp_tag !== e.tag || rsp_err !== e.err) begin
            fails++;
            $display("FAIL timeout_rsp: got z=%h tag=%0d err=%b want z=%h tag=%0d err=%b",
                     rsp_z, rsp_tag, rsp_err, e.z, e.tag, e.err);
          end
        end
      end
      @(negedge clk);
    end
    tests++;
    if (got !== 1) begin
      fails++; $display("FAIL timeout_count: got %0d responses want 1", got);
    end
  endtask

  task automatic test_reset_in_wait();
    int got = 0;
    mode = 2'd2; rsp_ready = 1'b1;
    send(64'd8, 64'd9, OP_OR, 4'd6, 64'd0, ERR_TIMEOUT);
    repeat (4) @(negedge clk);
    tests++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL rstwait_pre: busy=%b rsp_valid=%b want 1 0", busy, rsp_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 || alu_valid_i !== 1'b0) begin
      fails++;
      $display("FAIL rstwait_post: rsp_valid=%b req_ready=%b busy=%b vi=%b want 0 1 0 0",
               rsp_valid, req_ready, busy, alu_valid_i);
    end
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    @(negedge clk);
    tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL rstwait_stray: rsp_valid=%b busy=%b want 0 0", rsp_valid, busy);
    end
    mode = 2'd0;
    send(64'd41, 64'd0, OP_INC, 4'd2, 64'd42, ERR_OK);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (rsp_valid && rsp_ready) begin
        tests++;
        got++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL rstwait_rsp: unexpected response tag=%0d", rsp_tag);
        end else begin
          e = sb.pop_front();
          if (rsp_z !== e.z || rsp_tag !== e.tag || rsp_err !== e.err) begin
            fails++;
            $display("FAIL rstwait_rsp: got z=%h tag=%0d err=%b want z=%h tag=%0d err=%b",
                     rsp_z, rsp_tag, rsp_err, e.z, e.tag, e.err);
          end
        end
      end
      @(negedge clk);
    end
    tests++;
    if (got !== 1) begin
      fails++; $display("FAIL rstwait_count: got %0d responses want 1", got);
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_fill();
    test_illegal();
    test_slow();
    test_timeout();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
